// File: rtl/mult3_rr_sched_if.sv
// mult3_rr_sched_if
//   Bundles the request/result signals of mult3_rr_sched.
//   master : requester side (drives i_req and operands, sees acks/results)
//   slave  : scheduler side
//   i_req   [N]        level requests, held with operands until acked
//   i_a/b/c [N*WIDTH]  operands, requester k at [k*WIDTH +: WIDTH]
//   o_ack   [N]        one-hot accept pulse
//   o_valid/o_id/o_res result pulse, requester tag, rounded product
//   o_busy             products still in flight
interface mult3_rr_sched_if #(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int IDW   = 2
);
   logic [N-1:0]       i_req;
   logic [N*WIDTH-1:0] i_a;
   logic [N*WIDTH-1:0] i_b;
   logic [N*WIDTH-1:0] i_c;
   logic [N-1:0]       o_ack;
   logic               o_valid;
   logic [IDW-1:0]     o_id;
   logic [WIDTH-1:0]   o_res;
   logic               o_busy;

   modport master (
      output i_req, i_a, i_b, i_c,
      input  o_ack, o_valid, o_id, o_res, o_busy
   );

   modport slave (
      input  i_req, i_a, i_b, i_c,
      output o_ack, o_valid, o_id, o_res, o_busy
   );
endinterface

// File: rtl/mult3_rr_sched.sv
// mult3_rr_sched
//   Round-robin scheduler sharing one pipelined signed 3-input fixed-point
//   multiplier (Q(WIDTH-FRAC).FRAC) among N requesters.
//   One issue per cycle; result appears two cycles after the ack, tagged
//   with the requester index, in issue order. No backpressure.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset (flushes pipeline, ptr -> 0)
//     bus  mult3_rr_sched_if.slave (requests, operands, ack, results)
//   IDW must equal ceil(log2(N)); 1 <= FRAC <= WIDTH assumed.
module mult3_rr_sched #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 24,
   parameter int N     = 4,
   parameter int IDW   = 2
) (
   input logic             clk,
   input logic             rst,
   mult3_rr_sched_if.slave bus
);

   localparam int PW = 3 * WIDTH;

   // operand views, one lane per requester
   logic [N-1:0][WIDTH-1:0] a_v, b_v, c_v;
   assign a_v = bus.i_a;
   assign b_v = bus.i_b;
   assign c_v = bus.i_c;

   // arbitration state
   logic [IDW-1:0] ptr;
   logic [N-1:0]   ack_q;
   logic [N-1:0]   elig;
   logic           win_vld;
   logic [IDW-1:0] win_id;
   logic [N-1:0]   ack_nxt;
   logic [IDW-1:0] ptr_nxt;

   // vld_pipe[0]: stage 1, [1]: stage 2, [2]: output register
   logic [2:0]     vld_pipe;

   logic [WIDTH-1:0] s1_a, s1_b, s1_c;
   logic [IDW-1:0]   s1_id;
   logic [PW-1:0]    s2_p;
   logic [IDW-1:0]   s2_id;
   logic [WIDTH-1:0] res_q;
   logic [IDW-1:0]   id_q;

   // index ptr+i wrapped into 0..N-1
   function automatic logic [IDW-1:0] rot_idx(input logic [IDW-1:0] p, input int i);
      int j;
      j = int'(p) + i;
      if (j >= N) j = j - N;
      return IDW'(j);
   endfunction

   // A requester acked last edge is still holding i_req this cycle with
   // the old operands; masking it prevents issuing the same request twice.
   assign elig = bus.i_req & ~ack_q;

   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      for (int i = 0; i < N; i++) begin
         if (!win_vld && elig[rot_idx(ptr, i)]) begin
            win_vld = 1'b1;
            win_id  = rot_idx(ptr, i);
         end
      end
   end

   always_comb begin
      ack_nxt         = '0;
      ack_nxt[win_id] = win_vld;
      ptr_nxt         = (int'(win_id) == N - 1) ? '0 : win_id + 1'b1;
   end

   // control path: reset-cleared
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q    <= '0;
         ptr      <= '0;
         vld_pipe <= '0;
         res_q    <= '0;
         id_q     <= '0;
      end else begin
         ack_q    <= ack_nxt;
         vld_pipe <= {vld_pipe[1:0], win_vld};
         if (win_vld) ptr <= ptr_nxt;
         if (vld_pipe[1]) begin
            // round half up on the first discarded bit, wrap mod 2^WIDTH
            res_q <= s2_p[2*FRAC+WIDTH-1 -: WIDTH]
                   + {{(WIDTH-1){1'b0}}, s2_p[2*FRAC-1]};
            id_q  <= s2_id;
         end
      end
   end

   // full-width signed product; 3*WIDTH bits cannot overflow
   logic signed [PW-1:0] ea, eb, ec;
   assign ea = {{(2*WIDTH){s1_a[WIDTH-1]}}, s1_a};
   assign eb = {{(2*WIDTH){s1_b[WIDTH-1]}}, s1_b};
   assign ec = {{(2*WIDTH){s1_c[WIDTH-1]}}, s1_c};

   // datapath: no reset needed, qualified by vld_pipe
   always_ff @(posedge clk) begin
      if (win_vld) begin
         s1_a  <= a_v[win_id];
         s1_b  <= b_v[win_id];
         s1_c  <= c_v[win_id];
         s1_id <= win_id;
      end
      s2_p  <= ea * eb * ec;
      s2_id <= s1_id;
   end

   // bits of the product that never reach the result
   logic unused_pbits;
   generate
      if (2*FRAC+WIDTH < PW) begin : g_hi
         assign unused_pbits = ^{s2_p[PW-1:2*FRAC+WIDTH], s2_p[2*FRAC-1:0]};
      end else begin : g_nohi
         assign unused_pbits = ^s2_p[2*FRAC-1:0];
      end
   endgenerate

   assign bus.o_ack   = ack_q;
   assign bus.o_valid = vld_pipe[2];
   assign bus.o_id    = id_q;
   assign bus.o_res   = res_q;
   assign bus.o_busy  = vld_pipe[0] | vld_pipe[1];

endmodule

// File: tb/tb_mult3_rr_sched.sv
// tb_mult3_rr_sched
//   Directed checks of mult3_rr_sched: reset, basic multiply, sign and
//   rounding, round-robin order, single-holder alternation, mid-stream reset.
module tb_mult3_rr_sched;

   localparam int WIDTH = 32;
   localparam int FRAC  = 24;
   localparam int N     = 4;
   localparam int IDW   = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mult3_rr_sched_if #(.WIDTH(WIDTH), .N(N), .IDW(IDW)) bus ();

   mult3_rr_sched #(.WIDTH(WIDTH), .FRAC(FRAC), .N(N), .IDW(IDW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance one edge, sample 1 ns later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      bus.i_a[k*WIDTH +: WIDTH] = a;
      bus.i_b[k*WIDTH +: WIDTH] = b;
      bus.i_c[k*WIDTH +: WIDTH] = c;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.i_req = '0;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int nres;
      bus.i_req = '0;
      bus.i_a   = '0;
      bus.i_b   = '0;
      bus.i_c   = '0;

      // 1. reset held 3 cycles with all requests up
      rst = 1'b1;
      bus.i_req = 4'b1111;
      for (int s = 0; s < 3; s++) begin
         step();
         chk("rst_ack",   bus.o_ack,   4'b0000);
         chk("rst_valid", bus.o_valid, 1'b0);
         chk("rst_res",   bus.o_res,   32'h0);
         chk("rst_busy",  bus.o_busy,  1'b0);
      end
      rst = 1'b0;
      step();
      chk("rst_first_ack", bus.o_ack, 4'b0001);
      bus.i_req = '0;
      for (int s = 0; s < 4; s++) step();
      chk("rst_drain_busy", bus.o_busy, 1'b0);

      // 2. basic multiply: 2.0 * 1.5 * 0.5 on requester 1
      set_op(1, 32'h0200_0000, 32'h0180_0000, 32'h0080_0000);
      bus.i_req = 4'b0010;
      step();
      chk("mul_ack",  bus.o_ack,  4'b0010);
      chk("mul_busy", bus.o_busy, 1'b1);
      bus.i_req = '0;
      step();
      chk("mul_ack2",   bus.o_ack,   4'b0000);
      chk("mul_valid0", bus.o_valid, 1'b0);
      step();
      chk("mul_valid", bus.o_valid, 1'b1);
      chk("mul_id",    bus.o_id,    2'd1);
      chk("mul_res",   bus.o_res,   32'h0180_0000);

      // 3. sign (-1 * 2 * 3) then rounding (half LSB rounds up)
      set_op(0, 32'hFF00_0000, 32'h0200_0000, 32'h0300_0000);
      bus.i_req = 4'b0001;
      step();
      chk("sgn_ack", bus.o_ack, 4'b0001);
      set_op(0, 32'h0000_0001, 32'h0080_0000, 32'h0100_0000);
      step();
      chk("sgn_mask", bus.o_ack, 4'b0000);
      step();
      chk("rnd_ack",   bus.o_ack,   4'b0001);
      chk("sgn_valid", bus.o_valid, 1'b1);
      chk("sgn_id",    bus.o_id,    2'd0);
      chk("sgn_res",   bus.o_res,   32'hFA00_0000);
      bus.i_req = '0;
      step();
      chk("rnd_gap", bus.o_valid, 1'b0);
      step();
      chk("rnd_valid", bus.o_valid, 1'b1);
      chk("rnd_res",   bus.o_res,   32'h0000_0001);

      // 4. all four held 12 cycles: served 0,1,2,3,...
      do_reset();
      for (int k = 0; k < N; k++) set_op(k, 32'(k + 1), 32'h0100_0000, 32'h0100_0000);
      bus.i_req = 4'b1111;
      for (int s = 1; s <= 15; s++) begin
         if (s == 13) bus.i_req = '0;
         step();
         chk($sformatf("rr_ack%0d", s), bus.o_ack,
             (s <= 12) ? (64'd1 << ((s - 1) % 4)) : 64'd0);
         chk($sformatf("rr_valid%0d", s), bus.o_valid, (s >= 3 && s <= 14));
         if (s >= 3 && s <= 14) begin
            chk($sformatf("rr_id%0d", s),  bus.o_id,  (s - 3) % 4);
            chk($sformatf("rr_res%0d", s), bus.o_res, (s - 3) % 4 + 1);
         end
      end
      chk("rr_busy_end", bus.o_busy, 1'b0);

      // 5. single holder: 0.25 * 4.0 * -0.25 on requester 2, alternate acks
      do_reset();
      set_op(2, 32'h0040_0000, 32'h0400_0000, 32'hFFC0_0000);
      bus.i_req = 4'b0100;
      nres = 0;
      for (int s = 1; s <= 10; s++) begin
         if (s == 9) bus.i_req = '0;
         step();
         chk($sformatf("one_ack%0d", s), bus.o_ack,
             (s <= 8 && s % 2 == 1) ? 4'b0100 : 4'b0000);
         chk($sformatf("one_valid%0d", s), bus.o_valid, (s >= 3 && s % 2 == 1));
         if (bus.o_valid) begin
            nres++;
            chk($sformatf("one_id%0d", s),  bus.o_id,  2'd2);
            chk($sformatf("one_res%0d", s), bus.o_res, 32'hFFC0_0000);
         end
      end
      chk("one_count", nres, 4);

      // 6. reset one cycle after the second ack flushes both products
      do_reset();
      set_op(0, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000);
      set_op(1, 32'h0200_0000, 32'h0100_0000, 32'h0100_0000);
      set_op(3, 32'h0300_0000, 32'h0100_0000, 32'h0100_0000);
      bus.i_req = 4'b0011;
      step();
      chk("fl_ack0", bus.o_ack, 4'b0001);
      bus.i_req = 4'b0010;
      step();
      chk("fl_ack1", bus.o_ack, 4'b0010);
      bus.i_req = '0;
      rst = 1'b1;
      step();
      chk("fl_valid_rst", bus.o_valid, 1'b0);
      chk("fl_busy_rst",  bus.o_busy,  1'b0);
      rst = 1'b0;
      bus.i_req = 4'b1010;
      step();
      chk("fl_ack_after", bus.o_ack,   4'b0010);
      chk("fl_valid_a",   bus.o_valid, 1'b0);
      bus.i_req = 4'b1000;
      step();
      chk("fl_ack_next", bus.o_ack,   4'b1000);
      chk("fl_valid_b",  bus.o_valid, 1'b0);
      bus.i_req = '0;
      step();
      chk("fl_res1_v",  bus.o_valid, 1'b1);
      chk("fl_res1_id", bus.o_id,    2'd1);
      chk("fl_res1",    bus.o_res,   32'h0200_0000);
      step();
      chk("fl_res3_v",  bus.o_valid, 1'b1);
      chk("fl_res3_id", bus.o_id,    2'd3);
      chk("fl_res3",    bus.o_res,   32'h0300_0000);
      step();
      chk("fl_idle", bus.o_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
